// File: rtl/sig_stream_packer_if.sv
// Handshake bundle for sig_stream_packer: 256-bit capture side and 32-bit valid/ready beat side.
interface sig_stream_packer_if;
  logic         in_vld;
  logic [255:0] in_data;
  logic         out_vld;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;

  modport master (
    output in_vld, in_data, out_ready,
    input  out_vld, out_data, out_last
  );

  modport slave (
    input  in_vld, in_data, out_ready,
    output out_vld, out_data, out_last
  );
endinterface

// File: rtl/sig_stream_packer.sv
// Buffers 256-bit signature words from an unstallable source and re-emits them as MSB-first
// 32-bit beats, tracking word count, overflow and completion of one signature.
module sig_stream_packer #(
  parameter int unsigned SIG_WORDS  = 1088,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CntW      = $clog2(SIG_WORDS + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  sig_stream_packer_if.slave  bus,
  output logic                done,
  output logic                overflow,
  output logic [CntW-1:0]     word_cnt
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] SigWords = CntW'(SIG_WORDS);
  localparam logic [CntW-1:0] LastWord = CntW'(SIG_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  state_e state_q, state_d;

  logic [AddrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        beat_q, beat_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d, out_cnt_q, out_cnt_d;
  logic              overflow_q, overflow_d;
  logic [255:0]      mem_q [FIFO_DEPTH];
  logic [7:0][31:0]  head;

  logic empty, full, run, push, ovf_evt, hs, pop, last_hs;
  logic out_vld, out_last;
  logic [31:0] out_data;

  assign run   = (state_q == StRun);
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[AddrW] != wr_ptr_q[AddrW]) &&
                 (rd_ptr_q[AddrW-1:0] == wr_ptr_q[AddrW-1:0]);
  assign head  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign hs      = out_vld && bus.out_ready;
  assign pop     = hs && (beat_q == 3'd7);
  assign last_hs = out_last && bus.out_ready;

  // A full FIFO still takes a word when the head's final beat leaves in the same cycle.
  always_comb begin
    push    = 1'b0;
    ovf_evt = 1'b0;
    if (run && bus.in_vld && !start) begin
      if (word_cnt_q == SigWords) begin
        ovf_evt = 1'b1;
      end else if (full && !pop) begin
        ovf_evt = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    word_cnt_d = word_cnt_q;
    out_cnt_d  = out_cnt_q;
    overflow_d = overflow_q;
    if (start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      beat_d     = '0;
      word_cnt_d = '0;
      out_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
      end
      if (ovf_evt) overflow_d = 1'b1;
      if (hs) beat_d = beat_q + 1'b1;
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      word_cnt_q <= '0;
      out_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
      out_cnt_q  <= out_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= bus.in_data;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (start) state_d = StRun;
               else if (last_hs) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; lane 7 of the head (bits 255:224) goes out first.
  always_comb begin
    out_vld  = run && !empty;
    out_last = out_vld && (beat_q == 3'd7) && (out_cnt_q == LastWord);
    out_data = out_vld ? head[3'd7 - beat_q] : 32'd0;
    done     = (state_q == StDone);
  end

  assign bus.out_vld  = out_vld;
  assign bus.out_last = out_last;
  assign bus.out_data = out_data;
  assign overflow     = overflow_q;
  assign word_cnt     = word_cnt_q;

endmodule
